// File: rtl/cordic_arbiter.sv
// N_CH-way operand arbiter that feeds a single shared CORDIC core through a one-entry output register.
// Define CORDIC_ARB_ROUND_ROBIN_EN for round-robin priority; the default build uses fixed lowest-index priority.
module cordic_arbiter #(
   parameter int N_CH      = 4,
   parameter int DIN_WIDTH = 16,
   parameter int ID_WIDTH  = $clog2(N_CH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_CH-1:0]               s_valid,
   input  logic [N_CH*2*DIN_WIDTH-1:0]   s_data,
   output logic [N_CH-1:0]               s_ready,
   output logic                          m_valid,
   output logic [2*DIN_WIDTH-1:0]        m_data,
   output logic [ID_WIDTH-1:0]           m_id,
   input  logic                          m_ready
);

   localparam int DW2 = 2 * DIN_WIDTH;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DW2-1:0]      data_q, sel_data;
   logic [ID_WIDTH-1:0] id_q, win_id, ptr_q;
   logic [ID_WIDTH:0]   scan_idx;
   logic                found, load_en, xfer;

   // Scan channels starting at the pointer, wrapping past N_CH-1 back to 0.
   // NOTE: blocking assignments in always_comb; 'found' is read back within the same pass.
   always_comb begin
      win_id   = '0;
      scan_idx = '0;
      found    = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         scan_idx = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
         if (scan_idx >= (ID_WIDTH+1)'(N_CH))
            scan_idx = scan_idx - (ID_WIDTH+1)'(N_CH);
         if (!found && s_valid[scan_idx[ID_WIDTH-1:0]]) begin
            found  = 1'b1;
            win_id = scan_idx[ID_WIDTH-1:0];
         end
      end
   end

   assign load_en = (state_q == EMPTY) || m_ready;
   assign xfer    = load_en && found && !rst;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      s_ready  = '0;
      sel_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (win_id == ID_WIDTH'(k)) begin
            s_ready[k] = xfer;
            sel_data   = s_data[k*DW2 +: DW2];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (xfer) state_d = FULL;
         FULL: begin
            if (xfer)         state_d = FULL;
            else if (m_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // NOTE: the operand register is reset so m_data/m_id read zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         id_q   <= '0;
      end else if (xfer) begin
         data_q <= sel_data;
         id_q   <= win_id;
      end
   end

`ifdef CORDIC_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else if (xfer)
         ptr_q <= (win_id == ID_WIDTH'(N_CH-1)) ? '0 : win_id + 1'b1;
   end
`else
   assign ptr_q = '0;
`endif

   // Gating with rst keeps a held operand from being handed to the core during the reset cycle.
   assign m_valid = (state_q == FULL) && !rst;
   assign m_data  = rst ? '0 : data_q;
   assign m_id    = rst ? '0 : id_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter (N_CH=4, DIN_WIDTH=16); follows CORDIC_ARB_ROUND_ROBIN_EN if defined.
module tb_cordic_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   s_valid;
   logic [127:0] s_data;
   logic [3:0]   s_ready;
   logic         m_valid;
   logic [31:0]  m_data;
   logic [1:0]   m_id;
   logic         m_ready;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   bit   mdl_full = 1'b0;
   int   mdl_ptr  = 0;

   cordic_arbiter #(.N_CH(4), .DIN_WIDTH(16), .ID_WIDTH(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_id    (m_id),
      .m_ready (m_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ref_grant(input logic [3:0] sv, input int p);
      int idx;
      for (int i = 0; i < 4; i++) begin
         idx = (p + i) % 4;
         if (sv[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [127:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one cycle, check combinational outputs against the model, then advance the model.
   task automatic cycle(input logic r, input logic [3:0] sv, input logic mr, input logic [127:0] d);
      exp_t       e;
      int         w;
      logic [3:0] exp_ready;
      bit         drain;
      rst = r; s_valid = sv; m_ready = mr; s_data = d;
      #1;
      w = (!r && (!mdl_full || mr)) ? ref_grant(sv, mdl_ptr) : -1;
      exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
      check("s_ready", 64'(s_ready), 64'(exp_ready));
      check("m_valid", 64'(m_valid), 64'(mdl_full && !r));
      if (r) begin
         check("m_data_rst", 64'(m_data), 64'd0);
         check("m_id_rst", 64'(m_id), 64'd0);
      end else if (mdl_full && sb_q.size() > 0) begin
         check("m_data", 64'(m_data), 64'(sb_q[0].data));
         check("m_id", 64'(m_id), 64'(sb_q[0].id));
      end
      @(posedge clk);
      if (r) begin
         sb_q.delete();
         mdl_full = 1'b0;
         mdl_ptr  = 0;
      end else begin
         drain = mdl_full && mr;
         if (drain && sb_q.size() > 0) void'(sb_q.pop_front());
         if (w >= 0) begin
            e.id   = 2'(w);
            e.data = d[w*32 +: 32];
            sb_q.push_back(e);
            mdl_full = 1'b1;
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
            mdl_ptr = (w + 1) % 4;
`endif
         end else if (drain) begin
            mdl_full = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [127:0] d;
      int           skip_exp[3];
      rst = 1'b1; s_valid = '0; m_ready = 1'b0; s_data = '0;
      @(negedge clk);

      // Reset held with every channel requesting.
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111, 1'b1, rand_data());

      // All channels valid, core always ready.
      for (int j = 0; j < 6; j++) begin
         cycle(1'b0, 4'b1111, 1'b1, rand_data());
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
         check("all_valid_id", 64'(m_id), 64'(j % 4));
`else
         check("all_valid_id", 64'(m_id), 64'd0);
`endif
         check("all_valid_mv", 64'(m_valid), 64'd1);
      end

      // Channels 1 and 3 requesting.
      for (int j = 0; j < 5; j++) begin
         cycle(1'b0, 4'b1010, 1'b1, rand_data());
`ifndef CORDIC_ARB_ROUND_ROBIN_EN
         check("fixed_1010_id", 64'(m_id), 64'd1);
`endif
      end

      // Backpressure with an operand from channel 2 held.
      d = rand_data();
      d[95:64] = 32'h0003_0004;
      cycle(1'b0, 4'b0100, 1'b1, d);
      check("bp_load_id", 64'(m_id), 64'd2);
      check("bp_load_data", 64'(m_data), 64'h0003_0004);
      for (int j = 0; j < 5; j++) begin
         cycle(1'b0, 4'b1111, 1'b0, rand_data());
         check("bp_hold_id", 64'(m_id), 64'd2);
         check("bp_hold_data", 64'(m_data), 64'h0003_0004);
         check("bp_hold_mv", 64'(m_valid), 64'd1);
      end
      cycle(1'b0, 4'b1111, 1'b1, rand_data());
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
      check("bp_release_id", 64'(m_id), 64'd3);
`else
      check("bp_release_id", 64'(m_id), 64'd0);
`endif

      // Pointer left at 3, then channels 0 and 2 requesting.
      cycle(1'b0, 4'b0100, 1'b1, rand_data());
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
      skip_exp = '{0, 2, 0};
`else
      skip_exp = '{0, 0, 0};
`endif
      for (int j = 0; j < 3; j++) begin
         cycle(1'b0, 4'b0101, 1'b1, rand_data());
         check("wrap_skip_id", 64'(m_id), 64'(skip_exp[j]));
      end

      // Reset pulse while holding an operand from channel 1.
      cycle(1'b0, 4'b0010, 1'b1, rand_data());
      check("mid_rst_load_id", 64'(m_id), 64'd1);
      cycle(1'b1, 4'b1111, 1'b0, rand_data());
      check("mid_rst_mv", 64'(m_valid), 64'd0);
      check("mid_rst_id", 64'(m_id), 64'd0);
      check("mid_rst_data", 64'(m_data), 64'd0);
      cycle(1'b0, 4'b1111, 1'b1, rand_data());
      check("post_rst_id", 64'(m_id), 64'd0);
      cycle(1'b0, 4'b0000, 1'b1, rand_data());
      check("drain_mv", 64'(m_valid), 64'd0);

      // Random traffic with occasional backpressure and reset.
      for (int j = 0; j < 80; j++)
         cycle(($urandom_range(0, 29) == 0), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0), rand_data());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter DIN_WIDTH, default 16, width of each x and y operand.
REQ-003 SHALL have parameter ID_WIDTH, default $clog2(N_CH), width of the channel tag.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  N_CH  per-channel request valid.
REQ-007 SHALL have port s_data  input  N_CH*2*DIN_WIDTH  per-channel {y,x}; channel k occupies bits [2*DIN_WIDTH*(k+1)-1 : 2*DIN_WIDTH*k].
REQ-008 SHALL have port s_ready  output  N_CH  per-channel accept, one-hot or zero.
REQ-009 SHALL have port m_valid  output  1  operand valid toward shared CORDIC core.
REQ-010 SHALL have port m_data  output  2*DIN_WIDTH  selected {y,x}.
REQ-011 SHALL have port m_id  output  ID_WIDTH  index of channel that sourced m_data.
REQ-012 SHALL have port m_ready  input  1  core accepts m_data.

Function
REQ-013 SHALL transfer on a port when valid and ready are both high at a rising edge.
REQ-014 SHALL hold m_valid/m_data/m_id in an output register with states EMPTY (m_valid=0) and FULL (m_valid=1).
REQ-015 SHALL define load_en = EMPTY or (FULL and m_ready); s_ready SHALL be zero whenever load_en is low.
REQ-016 SHALL, when load_en is high and any s_valid is high, assert exactly one s_ready bit, for the winning channel, combinationally in that cycle.
REQ-017 SHALL, on a winning transfer, load winner's data and index into the output register at that edge (latency 1 cycle s_valid -> m_valid).
REQ-018 SHALL transition FULL->EMPTY when m_ready is high and no s_valid is high; EMPTY->FULL on any transfer; FULL->FULL on simultaneous drain and load.
REQ-019 SHALL sustain one transfer per cycle when m_ready stays high.
REQ-020 SHALL keep m_data and m_id stable while m_valid=1 and m_ready=0.
REQ-021 SHALL ignore s_data of non-granted channels; s_valid may drop without handshake without affecting state.
REQ-022 SHALL leave the arbitration pointer unchanged in cycles with no transfer.
REQ-023 SHALL never assert s_ready to a channel whose s_valid is low.

Reset
REQ-024 SHALL, while rst is high, drive m_valid=0, m_data=0, m_id=0, s_ready=0 and set pointer to 0 at the edge.
REQ-025 SHALL discard any held operand when rst asserts mid-operation; no s_ready SHALL be asserted during rst.
REQ-026 SHALL resume arbitration on the first edge after rst deasserts, channel 0 highest priority.

Configuration
REQ-027 SHALL support macro CORDIC_ARB_ROUND_ROBIN_EN.
REQ-028 With CORDIC_ARB_ROUND_ROBIN_EN defined: after a transfer from channel k, pointer SHALL become (k+1) mod N_CH; priority SHALL descend pointer, pointer+1, ..., wrapping N_CH-1 -> 0.
REQ-029 Without CORDIC_ARB_ROUND_ROBIN_EN: fixed priority, lowest asserted index wins; pointer logic SHALL be absent and pointer treated as constant 0.

Verification (N_CH=4, DIN_WIDTH=16)
REQ-030 Reset: rst=1 3 cycles with s_valid=4'b1111, m_ready=1 -> s_ready=0, m_valid=0 throughout; first post-reset grant to channel 0.
REQ-031 Round-robin, all valid, m_ready=1 -> m_id sequence 0,1,2,3,0,1 on consecutive cycles, m_valid continuously 1.
REQ-032 Fixed priority (macro undefined), s_valid=4'b1010 held -> m_id=1 every cycle, channel 3 never granted.
REQ-033 Backpressure: FULL with m_id=2, m_data=32'h0003_0004, m_ready=0 for 5 cycles -> s_ready=0, outputs unchanged; m_ready=1 -> next grant same cycle.
REQ-034 Wrap/skip: round-robin, pointer=3, s_valid=4'b0101 -> grant channel 0, then channel 2, then channel 0.
REQ-035 Mid-operation reset: FULL with m_id=1, rst pulsed 1 cycle -> m_valid=0 next edge, held operand never transferred, pointer 0.
